// File: rtl/bram_xfer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bram_xfer_ctrl_pkg
// Purpose : Shared types and constants for the BRAM transfer controller:
//           FSM state encoding, default bank counts, direction codes.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package bram_xfer_ctrl_pkg;

  localparam int DEF_NUM_WR_BANKS = 32;
  localparam int DEF_NUM_RD_BANKS = 16;

  localparam logic DIR_LOAD   = 1'b0;
  localparam logic DIR_UNLOAD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_UNLOAD = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } xfer_state_e;

endpackage
`default_nettype wire

// File: rtl/xfer_delay_line.sv
`default_nettype none
// ============================================================================
// Module  : xfer_delay_line
// Purpose : Fixed-depth shift register; output is the input delayed by
//           exactly DEPTH clock cycles. Always advances (no enable).
// Ports   : clk_i  - clock
//           rst_ni - asynchronous active-low reset, clears every stage
//           d_i    - WIDTH-bit input
//           q_o    - WIDTH-bit output, d_i delayed DEPTH cycles
// Rev     : 1.0 - initial release
// ============================================================================
module xfer_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/bram_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : bram_xfer_ctrl
// Purpose : Command-driven sequencer moving a banks x words region between
//           the AXI-Stream datapath and the bank BRAMs, bank-major.
//           Load : stream -> BRAM (demux_sel, bank_we, wr_addr)
//           Unload: BRAM -> stream (rd_en, rd_bank, rd_addr, then
//                   mux_sel/pack_valid after RD_LATENCY cycles)
// Ports   : aclk/aresetn        - clock, async active-low reset
//           cmd_*               - command handshake and fields
//           wr_valid            - parser word strobe
//           demux_sel/bank_we/wr_addr - write side
//           rd_stall            - hold read issue
//           rd_en/rd_bank/rd_addr     - read issue
//           mux_sel/pack_valid  - read return, aligned with BRAM data
//           busy/done/err       - status
// Config  : BRAM_XFER_CTRL_ERR_EN - enables sticky error detection on err;
//           when undefined err is tied low.
// Rev     : 1.0 - initial release
// ============================================================================
module bram_xfer_ctrl
  import bram_xfer_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int NUM_WR_BANKS = DEF_NUM_WR_BANKS,
  parameter int NUM_RD_BANKS = DEF_NUM_RD_BANKS,
  parameter int RD_LATENCY   = 2
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [ADDR_WIDTH-1:0]   cmd_base_addr,
  input  logic [ADDR_WIDTH-1:0]   cmd_words,
  input  logic [5:0]              cmd_banks,
  input  logic                    wr_valid,
  output logic [4:0]              demux_sel,
  output logic [NUM_WR_BANKS-1:0] bank_we,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic                    rd_stall,
  output logic                    rd_en,
  output logic [3:0]              rd_bank,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [3:0]              mux_sel,
  output logic                    pack_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam logic [5:0] WR_LIM     = 6'(NUM_WR_BANKS);
  localparam logic [5:0] RD_LIM     = 6'(NUM_RD_BANKS);
  localparam logic [2:0] DRAIN_LAST = 3'(RD_LATENCY - 1);

  xfer_state_e           state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] words_q;
  logic [ADDR_WIDTH-1:0] word_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [5:0]            banks_q;
  logic [5:0]            bank_q;
  logic [2:0]            drain_q;
  logic                  cmd_ready_q;
  logic                  busy_q;
  logic                  done_q;

  logic [5:0] w_lim;
  logic       w_clamp_hit;
  logic [5:0] w_banks_clamp;
  logic       w_wr_step;
  logic       w_rd_step;
  logic       w_word_last;
  logic       w_last;

  assign w_lim         = (cmd_dir == DIR_UNLOAD) ? RD_LIM : WR_LIM;
  assign w_clamp_hit   = cmd_banks > w_lim;
  assign w_banks_clamp = w_clamp_hit ? w_lim : cmd_banks;

  assign w_wr_step   = (state_q == ST_LOAD) && wr_valid;
  assign w_rd_step   = (state_q == ST_UNLOAD) && !rd_stall;
  assign w_word_last = (word_q == words_q - ADDR_WIDTH'(1));
  assign w_last      = w_word_last && (bank_q == banks_q - 6'd1);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      words_q     <= '0;
      word_q      <= '0;
      addr_q      <= '0;
      banks_q     <= '0;
      bank_q      <= '0;
      drain_q     <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Shared bank-major index walk for both directions; addr_q tracks
      // base + word so the address is available straight from a flop.
      if (w_wr_step || w_rd_step) begin
        if (w_word_last) begin
          word_q <= '0;
          addr_q <= base_q;
          bank_q <= bank_q + 6'd1;
        end else begin
          word_q <= word_q + ADDR_WIDTH'(1);
          addr_q <= addr_q + ADDR_WIDTH'(1);
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            base_q      <= cmd_base_addr;
            words_q     <= cmd_words;
            banks_q     <= w_banks_clamp;
            word_q      <= '0;
            bank_q      <= '0;
            addr_q      <= cmd_base_addr;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (cmd_words == '0 || cmd_banks == 6'd0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (cmd_dir == DIR_UNLOAD) begin
              state_q <= ST_UNLOAD;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (w_wr_step && w_last) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_UNLOAD: begin
          if (w_rd_step && w_last) begin
            state_q <= ST_DRAIN;
            drain_q <= '0;
          end
        end
        ST_DRAIN: begin
          // Wait out the return pipe so done follows the last pack_valid.
          if (drain_q == DRAIN_LAST) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 3'd1;
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          word_q      <= '0;
          bank_q      <= '0;
          addr_q      <= '0;
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Write side: enable is combinational so it lines up with parser data.
  assign demux_sel = bank_q[4:0];
  assign wr_addr   = addr_q;
  assign bank_we   = w_wr_step ? (NUM_WR_BANKS'(1) << bank_q) : '0;

  // Read side
  assign rd_en   = w_rd_step;
  assign rd_bank = bank_q[3:0];
  assign rd_addr = addr_q;

  // Return pipe: bank is zeroed for idle slots so mux_sel stays quiet.
  logic [4:0] w_pipe_in;
  logic [4:0] w_pipe_out;

  assign w_pipe_in = {w_rd_step, w_rd_step ? bank_q[3:0] : 4'd0};

  xfer_delay_line #(
    .DEPTH (RD_LATENCY),
    .WIDTH (5)
  ) u_ret_pipe (
    .clk_i  (aclk),
    .rst_ni (aresetn),
    .d_i    (w_pipe_in),
    .q_o    (w_pipe_out)
  );

  assign pack_valid = w_pipe_out[4];
  assign mux_sel    = w_pipe_out[3:0];

`ifdef BRAM_XFER_CTRL_ERR_EN
  logic       err_q;
  logic [1:0] w_prod_lo;

  // Only the low two bits decide divisibility by 4.
  assign w_prod_lo = cmd_words[1:0] * cmd_banks[1:0];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_q <= 1'b0;
    end else if ((wr_valid && state_q != ST_LOAD) ||
                 (state_q == ST_IDLE && cmd_valid &&
                  (w_clamp_hit || (cmd_dir == DIR_UNLOAD && w_prod_lo != 2'd0)))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_bram_xfer_ctrl
// Purpose : Directed self-checking bench for bram_xfer_ctrl (default
//           parameters, RD_LATENCY = 2). Honours BRAM_XFER_CTRL_ERR_EN for
//           the expected value of err.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_bram_xfer_ctrl;

`ifdef BRAM_XFER_CTRL_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_base_addr = '0;
  logic [15:0] cmd_words = '0;
  logic [5:0]  cmd_banks = '0;
  logic        wr_valid = 1'b0;
  logic [4:0]  demux_sel;
  logic [31:0] bank_we;
  logic [15:0] wr_addr;
  logic        rd_stall = 1'b0;
  logic        rd_en;
  logic [3:0]  rd_bank;
  logic [15:0] rd_addr;
  logic [3:0]  mux_sel;
  logic        pack_valid;
  logic        busy;
  logic        done;
  logic        err;

  bram_xfer_ctrl dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_dir       (cmd_dir),
    .cmd_base_addr (cmd_base_addr),
    .cmd_words     (cmd_words),
    .cmd_banks     (cmd_banks),
    .wr_valid      (wr_valid),
    .demux_sel     (demux_sel),
    .bank_we       (bank_we),
    .wr_addr       (wr_addr),
    .rd_stall      (rd_stall),
    .rd_en         (rd_en),
    .rd_bank       (rd_bank),
    .rd_addr       (rd_addr),
    .mux_sel       (mux_sel),
    .pack_valid    (pack_valid),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Presents a command for one cycle; returns at the negedge of the first
  // cycle after acceptance.
  task automatic send_cmd(input logic dir, input logic [15:0] base,
                          input logic [15:0] words, input logic [5:0] banks);
    @(negedge aclk);
    cmd_valid     = 1'b1;
    cmd_dir       = dir;
    cmd_base_addr = base;
    cmd_words     = words;
    cmd_banks     = banks;
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge aclk);
    aresetn  = 1'b0;
    wr_valid = 1'b0;
    rd_stall = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // Unload of 4 words x 2 banks from base 0; bit c of each mask is cycle c
  // after acceptance (cycle 1 = first UNLOAD cycle).
  task automatic run_unload(input string tag, input logic [15:0] stall,
                            input logic [15:0] en, input logic [15:0] pv,
                            input int done_cyc, input int ncyc);
    int ni = 0;
    int np = 0;
    int pv_cnt = 0;
    send_cmd(1'b1, 16'h0000, 16'd4, 6'd2);
    for (int c = 1; c <= ncyc; c++) begin
      rd_stall = stall[c];
      #1;
      check({tag, "_rd_en"}, rd_en, en[c]);
      if (en[c]) begin
        check({tag, "_rd_bank"}, rd_bank, ni / 4);
        check({tag, "_rd_addr"}, rd_addr, ni % 4);
        ni++;
      end
      check({tag, "_pack_valid"}, pack_valid, pv[c]);
      if (pv[c]) begin
        check({tag, "_mux_sel"}, mux_sel, np / 4);
        np++;
      end
      if (pack_valid) pv_cnt++;
      check({tag, "_done"}, done, (c == done_cyc));
      @(negedge aclk);
    end
    rd_stall = 1'b0;
    #1;
    check({tag, "_pv_total"}, pv_cnt, 8);
    check({tag, "_ready_after"}, cmd_ready, 1'b1);
  endtask

  // Waits for done with a cycle bound, counting rd_en cycles on the way.
  task automatic wait_done(input int bound, output int n_rd, output logic seen);
    n_rd = 0;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      #1;
      if (rd_en) n_rd++;
      if (done) seen = 1'b1;
      else @(negedge aclk);
    end
  endtask

  int   n_rd;
  logic seen;

  initial begin
    // ---- reset state ----
    @(negedge aclk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_pack_valid", pack_valid, 1'b0);
    check("rst_wr_addr", wr_addr, 16'h0);
    check("rst_err", err, 1'b0);
    @(negedge aclk);
    aresetn = 1'b1;

    // ---- load base 0x10, 3 words x 2 banks, continuous wr_valid ----
    send_cmd(1'b0, 16'h0010, 16'd3, 6'd2);
    wr_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k == 0) begin
        check("ld_cmd_ready_low", cmd_ready, 1'b0);
        check("ld_busy", busy, 1'b1);
      end
      check("ld_bank_we", bank_we, 64'(1) << (k / 3));
      check("ld_wr_addr", wr_addr, 16'h10 + k % 3);
      check("ld_demux_sel", demux_sel, k / 3);
      check("ld_done_early", done, 1'b0);
      @(negedge aclk);
    end
    wr_valid = 1'b0;
    #1;
    check("ld_done", done, 1'b1);
    check("ld_we_after", bank_we, 32'h0);
    @(negedge aclk);
    #1;
    check("ld_done_pulse", done, 1'b0);
    check("ld_ready_back", cmd_ready, 1'b1);

    // ---- load address wrap at 0xFFFF ----
    send_cmd(1'b0, 16'hFFFF, 16'd2, 6'd1);
    wr_valid = 1'b1;
    #1;
    check("wrap_addr0", wr_addr, 16'hFFFF);
    @(negedge aclk);
    #1;
    check("wrap_addr1", wr_addr, 16'h0000);
    check("wrap_we1", bank_we, 32'h1);
    @(negedge aclk);
    wr_valid = 1'b0;
    #1;
    check("wrap_done", done, 1'b1);

    // ---- unload 4 x 2, no stall ----
    run_unload("ul", 16'h0000, 16'h01FE, 16'h07F8, 11, 12);

    // ---- unload 4 x 2, stall cycles 4..6 ----
    run_unload("st", 16'h0070, 16'h0F8E, 16'h3E38, 14, 15);

    // ---- zero-word command ----
    send_cmd(1'b1, 16'h0000, 16'd0, 6'd2);
    #1;
    check("z_done", done, 1'b1);
    check("z_rd_en", rd_en, 1'b0);
    check("z_bank_we", bank_we, 32'h0);
    @(negedge aclk);
    #1;
    check("z_done_pulse", done, 1'b0);
    check("z_ready", cmd_ready, 1'b1);

    // ---- bank clamp: 20 requested on unload -> 16 ----
    send_cmd(1'b1, 16'h0000, 16'd1, 6'd20);
    wait_done(60, n_rd, seen);
    check("clamp_done_seen", seen, 1'b1);
    check("clamp_rd_count", n_rd, 16);
    check("clamp_err", err, ERR_EXP);

    // ---- reset during load word 2 ----
    pulse_reset();
    send_cmd(1'b0, 16'h0000, 16'd3, 6'd2);
    wr_valid = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    #1;
    check("mr_pre_addr", wr_addr, 16'd2);
    aresetn = 1'b0;
    #1;
    check("mr_bank_we", bank_we, 32'h0);
    check("mr_cmd_ready", cmd_ready, 1'b1);
    check("mr_busy", busy, 1'b0);
    check("mr_wr_addr", wr_addr, 16'h0);
    check("mr_demux", demux_sel, 5'd0);
    check("mr_err", err, 1'b0);
    wr_valid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      #1;
      check("mr_no_done", done, 1'b0);
      check("mr_idle_ready", cmd_ready, 1'b1);
    end

    // ---- error: wr_valid in IDLE ----
    check("e_clear", err, 1'b0);
    @(negedge aclk);
    wr_valid = 1'b1;
    @(negedge aclk);
    wr_valid = 1'b0;
    #1;
    check("e_wr_idle", err, ERR_EXP);
    @(negedge aclk);
    #1;
    check("e_sticky", err, ERR_EXP);

    // ---- error: unload 3 words x 1 bank (not a multiple of 4) ----
    pulse_reset();
    #1;
    check("e2_clear", err, 1'b0);
    send_cmd(1'b1, 16'h0000, 16'd3, 6'd1);
    wait_done(20, n_rd, seen);
    check("e2_done_seen", seen, 1'b1);
    check("e2_rd_count", n_rd, 3);
    check("e2_err", err, ERR_EXP);
    @(negedge aclk);
    @(negedge aclk);
    #1;
    check("e2_sticky", err, ERR_EXP);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_xfer_ctrl.md
# bram_xfer_ctrl

Sequencing controller for the transpose-convolution AXI-Stream datapath: drives the write-side demux select, bank write-enables and BRAM write address from the 16-bit parser valid strobe, and the read-side BRAM read address, mux select and packer valid strobe. It replaces ad-hoc external FSM control of the write/read counters with one command-driven block that moves a rectangular `banks × words` region between the stream and the bank BRAMs, bank-major.

## Interface
- `ADDR_WIDTH`, 16, BRAM address width
- `NUM_WR_BANKS`, 32, write banks (demux fan-out)
- `NUM_RD_BANKS`, 16, read banks (mux fan-in)
- `RD_LATENCY`, 2, BRAM read latency in cycles; legal range 1..4

Ports:
- `aclk` in 1: the only clock
- `aresetn` in 1: reset, asynchronous, active-low
- `cmd_valid` in 1: command request
- `cmd_ready` out 1: high only in IDLE
- `cmd_dir` in 1: 0 = load (stream→BRAM), 1 = unload (BRAM→stream)
- `cmd_base_addr` in ADDR_WIDTH: first address in every bank
- `cmd_words` in ADDR_WIDTH: words per bank
- `cmd_banks` in 6: bank count, ≤ NUM_WR_BANKS (load) or NUM_RD_BANKS (unload)
- `wr_valid` in 1: parser word valid (`bram_wr_enable`)
- `demux_sel` out 5: current write bank
- `bank_we` out NUM_WR_BANKS: one-hot write enable
- `wr_addr` out ADDR_WIDTH: write address
- `rd_stall` in 1: hold read issue (S2MM FIFO almost-full)
- `rd_en` out 1: BRAM read issue
- `rd_bank` out 4: bank being read
- `rd_addr` out ADDR_WIDTH: read address
- `mux_sel` out 4: bank select aligned with returning data
- `pack_valid` out 1: packer input valid (`bram_rd_enable`)
- `busy` out 1: not IDLE
- `done` out 1: one-cycle completion pulse
- `err` out 1: sticky error (macro-dependent)

## Operation
- States: IDLE, LOAD, UNLOAD, DRAIN, DONE.
- IDLE: `cmd_ready`=1; on `cmd_valid` latch command, clear bank/word indices. `cmd_words`=0 or `cmd_banks`=0 → DONE directly; else dir 0 → LOAD, dir 1 → UNLOAD.
- LOAD: `demux_sel`=bank index (registered), `wr_addr`=base+word index (registered). `bank_we`=onehot(bank) & `wr_valid`, combinational, same cycle as parser data. Per accepted word: word++; at word==words-1, word←0, bank++; after last word of last bank → DONE.
- UNLOAD: each cycle `rd_stall`=0: `rd_en`=1, `rd_bank`/`rd_addr` from indices, indices advance as in LOAD. `rd_stall`=1: `rd_en`=0, indices hold. After last issue → DRAIN.
- Return pipe: `rd_en` and `rd_bank` delayed RD_LATENCY cycles become `pack_valid` and `mux_sel`. Pipe always advances; stall does not freeze in-flight reads.
- DRAIN: RD_LATENCY cycles, then DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `wr_valid` outside LOAD is ignored (no `bank_we`).
- Address arithmetic modulo 2^ADDR_WIDTH (wraps silently).
- Out-of-range `cmd_banks` clamped to the direction's bank count.

## Timing
- Reset (async assert, sync release): state IDLE; `cmd_ready`=1; all other outputs 0, `err`=0, return pipe cleared.
- `cmd_ready` falls the cycle after acceptance.
- Load latency 0: word on `wr_valid` in cycle n written in cycle n.
- First `rd_en` the cycle after acceptance. `pack_valid` exactly RD_LATENCY cycles after matching `rd_en`.
- `done` asserts `RD_LATENCY+1` cycles after last `rd_en` (unload), 1 cycle after last write (load).
- Upstream must raise `rd_stall` ≥ RD_LATENCY cycles before the FIFO is full.
- Reset mid-operation: command abandoned, no `done`, pipe contents lost.

## Configuration
- `BRAM_XFER_CTRL_ERR_EN` defined: `err` sets on (a) `wr_valid` while not in LOAD, (b) unload command with `cmd_words*cmd_banks` not a multiple of 4 (packer/TLAST grouping), (c) clamped `cmd_banks`. Cleared only by reset.
- Undefined: `err` tied 0, no detection logic.

## Structure
- Shared package: state encoding, NUM_WR_BANKS/NUM_RD_BANKS defaults, DIR_LOAD/DIR_UNLOAD constants.
- One sub-module: `xfer_delay_line` (parameterised depth/width shift register carrying {valid, bank}).

## Test plan
- Load base 0x10, words 3, banks 2, `wr_valid` continuous → `bank_we` bit0 at addr 0x10,0x11,0x12, bit1 at 0x10..0x12, `done` on cycle 7.
- Unload base 0, words 4, banks 2, RD_LATENCY 2 → 8 `rd_en`, `pack_valid` 8 cycles starting 2 later, `mux_sel` 0×4 then 1×4, `done` once.
- Unload with `rd_stall` high for 3 cycles mid-transfer → indices hold, exactly 8 `pack_valid` total, in-flight words still emerge.
- Command with words 0 → `done` 1 cycle after acceptance, no `bank_we`/`rd_en`.
- `aresetn` low during LOAD word 2 → all outputs 0 immediately, IDLE, `cmd_ready`=1 after release.
- ERR_EN: `wr_valid` in IDLE, then unload words 3 banks 1 → `err`=1 and stays 1; without macro `err`=0.
